// File: rtl/syn_pkg.sv
// Shared timing constants and stamp layout used by the event stamper and
// its storage FIFO.
package syn_pkg;

  localparam int SEC_W   = 32;
  localparam int NS_W    = 32;
  localparam int STAMP_W = SEC_W + NS_W;
  localparam int CNT_W   = 7;
  localparam int OVF_W   = 16;

  localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

  // Seconds occupy the upper word so the packed value reads {sec, ns}.
  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
  } stamp_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding event stamps.
// When empty, rd_data keeps showing the most recently popped entry.
module evt_fifo
  import syn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             wr_en,
  input  stamp_t           wr_data,
  input  logic             rd_en,
  output stamp_t           rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stamp_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  stamp_t           last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? last_q : mem[rd_ptr];
  assign count   = cnt;

  // Storage array write; contents carry no reset.
  always_ff @(posedge clk_sys) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer, occupancy and held-output bookkeeping.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/evt_stamp.sv
// Event time stamper: synchronises an external event, detects its rising
// edge, stamps it with latency-compensated UTC time and queues the stamp.
// Optional glitch filter enabled by defining EVT_STAMP_FILT_EN.
module evt_stamp
  import syn_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int LAT_NS   = 30,
  parameter int FILT_CYC = 4
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               evt_in,
  input  logic               en,
  input  logic [SEC_W-1:0]   utc_sec,
  input  logic [NS_W-1:0]    now_ns,
  input  logic               rd_en,
  output logic [STAMP_W-1:0] rd_data,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output logic [OVF_W-1:0]   ovf_cnt
);

  // Subtract the fixed input latency, borrowing a second when needed.
  function automatic stamp_t compensate(input logic [SEC_W-1:0] sec,
                                        input logic [NS_W-1:0]  ns);
    stamp_t s;
    if (ns >= NS_W'(LAT_NS)) begin
      s.sec = sec;
      s.ns  = ns - NS_W'(LAT_NS);
    end else begin
      s.sec = sec - 1'b1;
      s.ns  = ns + NS_PER_SEC - NS_W'(LAT_NS);
    end
    return s;
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic       meta_p0;
  logic       lvl_p1;
  logic [1:0] warm;
  logic       edge_p0;
  stamp_t     stamp_p1;
  logic       vld_p1;
  stamp_t     head;
  logic       fifo_full;
  logic       drop;

  // Two-flop synchroniser; warm counts cycles since reset so that levels
  // cleared by reset are never mistaken for real samples.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      lvl_p1  <= 1'b0;
      warm    <= '0;
    end else begin
      meta_p0 <= evt_in;
      lvl_p1  <= meta_p0;
      if (warm != 2'd3) begin
        warm <= warm + 1'b1;
      end
    end
  end

`ifdef EVT_STAMP_FILT_EN
  localparam int FW = $clog2(FILT_CYC + 1);

  logic [FW-1:0] hi_run;
  logic [FW-1:0] lo_run;
  logic          lo_ok;

  // Run-length tracking of the synchronised level; lo_ok remembers whether
  // the low run preceding the current high run was long enough.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      hi_run <= '0;
      lo_run <= '0;
      lo_ok  <= 1'b0;
    end else if (warm >= 2'd2) begin
      if (lvl_p1) begin
        lo_run <= '0;
        if (hi_run != FW'(FILT_CYC)) begin
          hi_run <= hi_run + 1'b1;
        end
      end else begin
        hi_run <= '0;
        if (lo_run != FW'(FILT_CYC)) begin
          lo_run <= lo_run + 1'b1;
        end
        lo_ok <= (lo_run >= FW'(FILT_CYC - 1));
      end
    end
  end

  // Accept exactly in the cycle the high run reaches FILT_CYC.
  assign edge_p0 = en && (warm >= 2'd2) && lvl_p1 && lo_ok &&
                   (hi_run == FW'(FILT_CYC - 1));
`else
  logic lvl_p2;

  // Previous synchronised level for plain edge detection.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      lvl_p2 <= 1'b0;
    end else begin
      lvl_p2 <= lvl_p1;
    end
  end

  assign edge_p0 = en && (warm == 2'd3) && lvl_p1 && !lvl_p2;
`endif

  // ---- stage p0 -> p1: capture the compensated stamp ----
  always_ff @(posedge clk_sys) begin
    if (edge_p0) begin
      stamp_p1 <= compensate(utc_sec, now_ns);
    end
  end

  // Valid flag for the captured stamp; reset discards an in-flight stamp.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= edge_p0;
    end
  end

  // ---- stage p1: push into storage ----
  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .wr_en   (vld_p1),
    .wr_data (stamp_p1),
    .rd_en   (rd_en),
    .rd_data (head),
    .empty   (empty),
    .full    (fifo_full),
    .count   (count)
  );

  assign rd_data = head;
  // A full FIFO only loses the stamp when no pop makes room this cycle.
  assign drop    = vld_p1 && fifo_full && !rd_en;

  // Dropped-stamp counter.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

endmodule

// File: tb/tb_evt_stamp.sv
// Self-checking bench for evt_stamp: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_evt_stamp;
  import syn_pkg::*;

  localparam int DEPTH    = 8;
  localparam int LAT_NS   = 30;
  localparam int FILT_CYC = 4;
`ifdef EVT_STAMP_FILT_EN
  localparam int D = FILT_CYC;
`else
  localparam int D = 1;
`endif
  localparam int W   = D + 2;
  localparam int GAP = 2 * FILT_CYC + 2;
  localparam int HL  = 2 * FILT_CYC + 4;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        evt_in  = 1'b0;
  logic        en      = 1'b0;
  logic [31:0] utc_sec = '0;
  logic [31:0] now_ns  = '0;
  logic        rd_en   = 1'b0;
  logic [63:0] rd_data;
  logic        empty;
  logic [6:0]  count;
  logic [15:0] ovf_cnt;

  int checks   = 0;
  int failures = 0;

  evt_stamp #(
    .DEPTH    (DEPTH),
    .LAT_NS   (LAT_NS),
    .FILT_CYC (FILT_CYC)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .evt_in  (evt_in),
    .en      (en),
    .utc_sec (utc_sec),
    .now_ns  (now_ns),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference stamp: absolute time in ns minus latency, split into sec/ns,
  // with the seconds field wrapping modulo 2^32.
  function automatic logic [63:0] ref_stamp(input logic [31:0] s, input logic [31:0] ns);
    longint si;
    longint ni;
    longint tot;
    longint wrap;
    si   = s;
    ni   = ns;
    wrap = 64'd4294967296 * 64'd1000000000;
    tot  = si * 1000000000 + ni - LAT_NS;
    if (tot < 0) tot = tot + wrap;
    return {32'(tot / 1000000000), 32'(tot % 1000000000)};
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] mq[$];
  logic [63:0] m_last;
  int          m_ovf;
  int          n_since;
  bit          hist[$];
  bit          pend_v;
  logic [63:0] pend;
  bit          started = 0;

  // hist[k] is the evt_in value sampled k clock edges ago. An edge is seen
  // two samples after it arrives, and only when every sample involved was
  // taken after reset release.
  function automatic bit edge_seen();
    bit ok;
`ifdef EVT_STAMP_FILT_EN
    ok = (n_since >= 2 * FILT_CYC + 2);
    for (int k = 2; k <= FILT_CYC + 1; k++) if (!hist[k]) ok = 0;
    for (int k = FILT_CYC + 2; k <= 2 * FILT_CYC + 1; k++) if (hist[k]) ok = 0;
`else
    ok = (n_since >= 4) && hist[2] && !hist[3];
`endif
    return ok;
  endfunction

  always @(posedge clk_sys) begin
    if (rst) begin
      started = 1;
      mq.delete();
      m_last  = '0;
      m_ovf   = 0;
      n_since = 0;
      pend_v  = 0;
      hist.delete();
      for (int k = 0; k < HL; k++) hist.push_back(1'b0);
    end else if (started) begin
      if (n_since < 1000) n_since++;
      hist.push_front(evt_in);
      void'(hist.pop_back());
      if (rd_en && mq.size() > 0) m_last = mq.pop_front();
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend);
        else if (m_ovf < 65535) m_ovf++;
      end
      pend_v = en && edge_seen();
      if (pend_v) pend = ref_stamp(utc_sec, now_ns);
    end
    #1;
    if (started) begin
      check("cyc_count", 64'(count), 64'(mq.size()));
      check("cyc_empty", 64'(empty), 64'(mq.size() == 0));
      check("cyc_ovf", 64'(ovf_cnt), 64'(m_ovf));
      check("cyc_rd_data", rd_data, (mq.size() > 0) ? mq[0] : m_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);
  endtask

  task automatic pulse(input logic [31:0] s, input logic [31:0] ns, input int w);
    utc_sec = s;
    now_ns  = ns;
    evt_in  = 1'b1;
    tick(w);
    evt_in  = 1'b0;
    tick(GAP);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick(12);

    // basic stamp
    pulse(32'd100, 32'd500, W);
    check("basic_data", rd_data, {32'd100, 32'd470});
    check("basic_empty", 64'(empty), 64'd0);
    check("basic_count", 64'(count), 64'd1);
    pop();
    check("basic_popped", 64'(empty), 64'd1);

    // borrow a second
    pulse(32'd100, 32'd10, W);
    check("borrow_data", rd_data, {32'd99, 32'd999_999_980});
    pop();

    // seconds wrap
    pulse(32'd0, 32'd5, W);
    check("wrap_data", rd_data, {32'hFFFF_FFFF, 32'd999_999_975});
    pop();

    // disabled: no stamp
    en = 1'b0;
    pulse(32'd7, 32'd700, W);
    check("dis_count", 64'(count), 64'd0);
    en = 1'b1;

    // overflow with nine edges
    do_reset();
    for (int i = 0; i < 9; i++) pulse(32'd200, 32'(1000 + i), W);
    check("ovf_count", 64'(count), 64'd8);
    check("ovf_cnt", 64'(ovf_cnt), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", rd_data, {32'd200, 32'(970 + i)});
      pop();
    end
    check("drain_empty", 64'(empty), 64'd1);
    pop();
    check("underflow_count", 64'(count), 64'd0);
    check("hold_data", rd_data, {32'd200, 32'd977});

    // push coincident with pop while full
    do_reset();
    for (int i = 0; i < 8; i++) pulse(32'd300, 32'(2000 + i), W);
    utc_sec = 32'd300;
    now_ns  = 32'd5000;
    evt_in  = 1'b1;
    tick(2 + D);
    rd_en = 1'b1;
    tick(1);
    rd_en  = 1'b0;
    evt_in = 1'b0;
    tick(GAP);
    check("coin_count", 64'(count), 64'd8);
    check("coin_ovf", 64'(ovf_cnt), 64'd0);
    for (int i = 1; i < 8; i++) begin
      check("coin_order", rd_data, {32'd300, 32'(1970 + i)});
      pop();
    end
    check("coin_last", rd_data, {32'd300, 32'd4970});
    pop();

`ifdef EVT_STAMP_FILT_EN
    // glitch filter
    do_reset();
    pulse(32'd400, 32'd900, 2);
    check("filt_short", 64'(count), 64'd0);
    pulse(32'd400, 32'd900, 6);
    check("filt_long", 64'(count), 64'd1);
    check("filt_data", rd_data, {32'd400, 32'd870});
`endif

    // reset one cycle after edge detect, evt held high across release
    do_reset();
    utc_sec = 32'd500;
    now_ns  = 32'd600;
    evt_in  = 1'b1;
    tick(2 + D);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);
    evt_in = 1'b0;
    tick(GAP);
    check("rstmid_count", 64'(count), 64'd0);
    check("rstmid_empty", 64'(empty), 64'd1);

    // randomized traffic
    do_reset();
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 3) == 0) evt_in = ~evt_in;
        en      = ($urandom_range(0, 7) != 0);
        rd_en   = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
        utc_sec = $urandom;
        now_ns  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 59)
                                              : $urandom_range(0, 999_999_999);
        rst     = ($urandom_range(0, 499) == 0);
        tick(1);
      end
    end
    rst    = 1'b0;
    rd_en  = 1'b0;
    evt_in = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
